// File: rtl/team_06_tremolo.sv
// Tremolo effect: amplitude-modulates an offset-binary sample stream with an
// internal triangle LFO; bypasses with identical one-cycle latency when disabled.
module team_06_tremolo #(
    parameter int RATE_DIV = 64,
    parameter int DEPTH    = 192
) (
    input  logic       clkdiv,
    input  logic       rst,
    input  logic [7:0] audio_in,
    input  logic       enable,
    output logic [7:0] audio_out
);

    localparam int              PW         = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(RATE_DIV - 1);
    localparam logic [7:0]      DEPTH_C    = 8'(DEPTH);

    logic [7:0]         lfo_q, lfo_d;
    logic               dir_q, dir_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [7:0]         out_q, out_d;

    logic [15:0]        lfoDepth;
    logic [8:0]         gainP1;
    logic signed [8:0]  dev;
    logic signed [18:0] prod;
    logic signed [18:0] shifted;
    logic signed [18:0] biased;

    // Triangle LFO: bounces 0..255..0 without repeating a peak value (dir 0 = up).
    always_comb begin
        lfo_d   = lfo_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        if (!enable) begin
            lfo_d   = 8'd0;
            dir_d   = 1'b0;
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (!dir_q) begin
                if (lfo_q == 8'd255) begin
                    lfo_d = 8'd254;
                    dir_d = 1'b1;
                end else begin
                    lfo_d = lfo_q + 8'd1;
                end
            end else begin
                if (lfo_q == 8'd0) begin
                    lfo_d = 8'd1;
                    dir_d = 1'b0;
                end else begin
                    lfo_d = lfo_q - 8'd1;
                end
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // gain+1 = 256 - ((lfo*DEPTH)>>8), so lfo=0 multiplies by exactly 256.
    always_comb begin
        lfoDepth = {8'd0, lfo_q} * {8'd0, DEPTH_C};
        gainP1   = 9'd256 - 9'(lfoDepth >> 8);
        dev      = $signed({1'b0, audio_in}) - 9'sd128;
        prod     = 19'(dev) * 19'($signed({1'b0, gainP1}));
        shifted  = prod >>> 8;
        biased   = shifted + 19'sd128;
    end

    always_comb begin
        out_d = audio_in;
        if (enable) begin
            if (biased < 19'sd0) begin
                out_d = 8'd0;
            end else if (biased > 19'sd255) begin
                out_d = 8'd255;
            end else begin
                out_d = biased[7:0];
            end
        end
    end

    always_ff @(posedge clkdiv or negedge rst) begin
        if (!rst) begin
            lfo_q   <= 8'd0;
            dir_q   <= 1'b0;
            presc_q <= '0;
            out_q   <= 8'h80;
        end else begin
            lfo_q   <= lfo_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            out_q   <= out_d;
        end
    end

    assign audio_out = out_q;

endmodule

// File: tb/tb_team_06_tremolo.sv
// Directed bench for team_06_tremolo: RATE_DIV=1, DEPTH=255 main instance plus
// a DEPTH=0 instance that must stay a pass-through.
module tb_team_06_tremolo;

    logic       clk;
    logic       rst;
    logic [7:0] audioIn;
    logic       enable;
    logic [7:0] audioOut;
    logic [7:0] audioIn0;
    logic [7:0] audioOut0;

    int total = 0;
    int bad   = 0;

    team_06_tremolo #(.RATE_DIV(1), .DEPTH(255)) dut (
        .clkdiv   (clk),
        .rst      (rst),
        .audio_in (audioIn),
        .enable   (enable),
        .audio_out(audioOut)
    );

    team_06_tremolo #(.RATE_DIV(1), .DEPTH(0)) dut0 (
        .clkdiv   (clk),
        .rst      (rst),
        .audio_in (audioIn0),
        .enable   (enable),
        .audio_out(audioOut0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One disabled cycle to restart the LFO, then n enabled edges at 100 and
    // one more edge carrying 'sample'; audio_out then reflects lfo phase n.
    task automatic applyStimulus(input int n, input logic [7:0] sample);
        enable  = 1'b0;
        audioIn = 8'd100;
        tick();
        enable = 1'b1;
        repeat (n) tick();
        audioIn = sample;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        audioIn  = 8'd100;
        audioIn0 = 8'd100;

        #1 rst = 1'b0;
        #1;
        checkOutput("reset_out_async", audioOut, 8'h80);
        checkOutput("reset_lfo", dut.lfo_q, 0);
        tick();
        checkOutput("reset_out_held", audioOut, 8'h80);

        rst = 1'b1;
        tick();
        checkOutput("bypass_100", audioOut, 100);
        audioIn = 8'd37;
        #1;
        checkOutput("bypass_registered", audioOut, 100);
        tick();
        checkOutput("bypass_37", audioOut, 37);
        checkOutput("bypass_lfo", dut.lfo_q, 0);

        enable  = 1'b1;
        audioIn = 8'd100;
        for (int i = 0; i <= 510; i++) begin
            tick();
            checkOutput("depth0_pass", audioOut0, 100);
            if (i == 0)   checkOutput("sweep_0", audioOut, 100);
            if (i == 128) checkOutput("sweep_128", audioOut, 113);
            if (i == 254) checkOutput("sweep_lfo_peak", dut.lfo_q, 255);
            if (i == 255) checkOutput("sweep_255", audioOut, 127);
            if (i == 255) checkOutput("sweep_dir_down", dut.dir_q, 1);
            if (i == 255) checkOutput("sweep_lfo_254", dut.lfo_q, 254);
            if (i == 383) checkOutput("sweep_383", audioOut, 113);
            if (i == 509) checkOutput("sweep_lfo_trough", dut.lfo_q, 0);
            if (i == 510) checkOutput("sweep_510", audioOut, 100);
            if (i == 510) checkOutput("sweep_lfo_1", dut.lfo_q, 1);
        end

        applyStimulus(255, 8'd255);
        checkOutput("peak_in255", audioOut, 128);
        applyStimulus(255, 8'd0);
        checkOutput("peak_in0", audioOut, 127);
        applyStimulus(0, 8'd255);
        checkOutput("zero_in255", audioOut, 255);
        applyStimulus(0, 8'd0);
        checkOutput("zero_in0", audioOut, 0);

        enable  = 1'b0;
        audioIn = 8'h80;
        tick();
        enable = 1'b1;
        for (int i = 0; i <= 510; i++) begin
            tick();
            checkOutput("silence", audioOut, 8'h80);
        end

        applyStimulus(100, 8'd100);
        checkOutput("phase_100", audioOut, 110);
        checkOutput("phase_lfo_101", dut.lfo_q, 101);
        enable = 1'b0;
        tick();
        checkOutput("phase_disable_out", audioOut, 100);
        checkOutput("phase_disable_lfo", dut.lfo_q, 0);
        enable = 1'b1;
        tick();
        checkOutput("phase_restart_out", audioOut, 100);
        checkOutput("phase_restart_lfo", dut.lfo_q, 1);

        applyStimulus(200, 8'd100);
        checkOutput("mode_on_200", audioOut, 121);
        enable = 1'b0;
        tick();
        checkOutput("mode_off_next", audioOut, 100);

        applyStimulus(50, 8'd100);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_out", audioOut, 8'h80);
        checkOutput("midrst_lfo", dut.lfo_q, 0);
        checkOutput("midrst_dir", dut.dir_q, 0);
        tick();
        checkOutput("midrst_held", audioOut, 8'h80);
        rst = 1'b1;
        tick();
        checkOutput("postrst_out", audioOut, 100);
        checkOutput("postrst_lfo", dut.lfo_q, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
